// File: rtl/tp_monitor_if.sv
// Pixel-stream and result bundle for tp_monitor.
// The master modport is the video source, the slave modport is the monitor.
interface tp_monitor_if #(
  parameter int unsigned CNT_W = 12
);
  logic             vsync_i;
  logic             hsync_i;
  logic             dval_i;
  logic [7:0]       rdata_i;
  logic [7:0]       gdata_i;
  logic [7:0]       bdata_i;
  logic             frame_done_o;
  logic [CNT_W-1:0] h_active_o;
  logic [CNT_W-1:0] v_active_o;
  logic [15:0]      frame_cnt_o;
  logic             err_o;
  logic [7:0]       err_cnt_o;
  logic             locked_o;
  logic [15:0]      checksum_o;

  modport master (
    output vsync_i, hsync_i, dval_i, rdata_i, gdata_i, bdata_i,
    input  frame_done_o, h_active_o, v_active_o, frame_cnt_o, err_o, err_cnt_o, locked_o,
           checksum_o
  );

  modport slave (
    input  vsync_i, hsync_i, dval_i, rdata_i, gdata_i, bdata_i,
    output frame_done_o, h_active_o, v_active_o, frame_cnt_o, err_o, err_cnt_o, locked_o,
           checksum_o
  );
endinterface

// File: rtl/tp_monitor.sv
// Video timing monitor: measures active size, line-width consistency and lock per frame.
// The per-frame pixel checksum is built only when TP_MONITOR_CHECKSUM_EN is defined.
module tp_monitor #(
  parameter int unsigned CNT_W       = 12,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input logic         px_clk,
  input logic         sys_rst,
  tp_monitor_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  localparam int unsigned      StrW    = $clog2(LOCK_FRAMES + 2);
  localparam logic [StrW-1:0]  LockMax = StrW'(LOCK_FRAMES);
  localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic             vs_q, hs_q, dv_q, vs_prev_q, hs_prev_q;
  logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [CNT_W-1:0] line_cnt_q, line_cnt_d;
  logic [CNT_W-1:0] ref_w_q, ref_w_d;
  logic             ref_vld_q, ref_vld_d;
  logic             err_flag_q, err_flag_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             locked_q, locked_d;
  logic             prev_vld_q, prev_vld_d;
  logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic [StrW-1:0]  streak_q, streak_d, streak_inc;

  logic             vs_rise, hs_rise, pix_nz, width_bad, err_fin, same_timing;
  logic [CNT_W-1:0] line_cnt_inc, lines_fin, ref_fin, pix_base;

  always_ff @(posedge px_clk or posedge sys_rst) begin
    if (sys_rst) begin
      vs_q      <= 1'b0;
      hs_q      <= 1'b0;
      dv_q      <= 1'b0;
      vs_prev_q <= 1'b0;
      hs_prev_q <= 1'b0;
    end else begin
      vs_q      <= bus.vsync_i;
      hs_q      <= bus.hsync_i;
      dv_q      <= bus.dval_i;
      vs_prev_q <= vs_q;
      hs_prev_q <= hs_q;
    end
  end

  assign vs_rise      = vs_q & ~vs_prev_q;
  assign hs_rise      = hs_q & ~hs_prev_q;
  assign pix_nz       = (pix_cnt_q != '0);
  assign width_bad    = ref_vld_q & (pix_cnt_q != ref_w_q);
  assign line_cnt_inc = (line_cnt_q == CntMax) ? line_cnt_q : line_cnt_q + 1'b1;
  // A pixel sampled together with a sync edge belongs to the line/frame that edge opens.
  assign pix_base     = (vs_rise | hs_rise) ? '0 : pix_cnt_q;

  // Results of the frame closed by this vsync edge, including its still-open last line.
  assign lines_fin   = pix_nz ? line_cnt_inc : line_cnt_q;
  assign ref_fin     = ref_vld_q ? ref_w_q : (pix_nz ? pix_cnt_q : '0);
  assign err_fin     = err_flag_q | (pix_nz & width_bad) | (lines_fin == '0);
  assign same_timing = prev_vld_q & (ref_fin == h_q) & (lines_fin == v_q);
  assign streak_inc  = (streak_q == LockMax) ? streak_q : streak_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    pix_cnt_d   = pix_cnt_q;
    line_cnt_d  = line_cnt_q;
    ref_w_d     = ref_w_q;
    ref_vld_d   = ref_vld_q;
    err_flag_d  = err_flag_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    h_d         = h_q;
    v_d         = v_q;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    locked_d    = locked_q;
    prev_vld_d  = prev_vld_q;
    streak_d    = streak_q;
    unique case (state_q)
      StIdle: begin
        if (vs_rise) begin
          state_d    = StActive;
          pix_cnt_d  = '0;
          line_cnt_d = '0;
          ref_w_d    = '0;
          ref_vld_d  = 1'b0;
          err_flag_d = 1'b0;
        end
      end
      StActive: begin
        pix_cnt_d = (dv_q && pix_base != CntMax) ? pix_base + 1'b1 : pix_base;
        if (vs_rise) begin
          done_d      = 1'b1;
          err_d       = err_fin;
          h_d         = ref_fin;
          v_d         = lines_fin;
          frame_cnt_d = frame_cnt_q + 16'd1;
          if (err_fin && err_cnt_q != 8'hff) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
          streak_d    = (same_timing && !err_fin) ? streak_inc : '0;
          locked_d    = (streak_d >= LockMax);
          prev_vld_d  = 1'b1;
          line_cnt_d  = '0;
          ref_w_d     = '0;
          ref_vld_d   = 1'b0;
          err_flag_d  = 1'b0;
        end else if (hs_rise && pix_nz) begin
          line_cnt_d = line_cnt_inc;
          if (!ref_vld_q) begin
            ref_w_d   = pix_cnt_q;
            ref_vld_d = 1'b1;
          end else if (width_bad) begin
            err_flag_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge px_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= StIdle;
      pix_cnt_q   <= '0;
      line_cnt_q  <= '0;
      ref_w_q     <= '0;
      ref_vld_q   <= 1'b0;
      err_flag_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      h_q         <= '0;
      v_q         <= '0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
      locked_q    <= 1'b0;
      prev_vld_q  <= 1'b0;
      streak_q    <= '0;
    end else begin
      state_q     <= state_d;
      pix_cnt_q   <= pix_cnt_d;
      line_cnt_q  <= line_cnt_d;
      ref_w_q     <= ref_w_d;
      ref_vld_q   <= ref_vld_d;
      err_flag_q  <= err_flag_d;
      done_q      <= done_d;
      err_q       <= err_d;
      h_q         <= h_d;
      v_q         <= v_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
      locked_q    <= locked_d;
      prev_vld_q  <= prev_vld_d;
      streak_q    <= streak_d;
    end
  end

  assign bus.frame_done_o = done_q;
  assign bus.err_o        = err_q;
  assign bus.h_active_o   = h_q;
  assign bus.v_active_o   = v_q;
  assign bus.frame_cnt_o  = frame_cnt_q;
  assign bus.err_cnt_o    = err_cnt_q;
  assign bus.locked_o     = locked_q;

`ifdef TP_MONITOR_CHECKSUM_EN
  logic [7:0]  r_q, g_q, b_q;
  logic [15:0] px_sum, cks_acc_q, cks_acc_d, cks_q, cks_d;

  always_ff @(posedge px_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_q <= '0;
      g_q <= '0;
      b_q <= '0;
    end else begin
      r_q <= bus.rdata_i;
      g_q <= bus.gdata_i;
      b_q <= bus.bdata_i;
    end
  end

  assign px_sum = 16'(r_q) + 16'(g_q) + 16'(b_q);

  always_comb begin
    cks_acc_d = vs_rise ? '0 : cks_acc_q;
    cks_d     = cks_q;
    if (state_q == StActive) begin
      if (vs_rise) begin
        cks_d = cks_acc_q;
      end
      if (dv_q) begin
        cks_acc_d = cks_acc_d + px_sum;
      end
    end
  end

  always_ff @(posedge px_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cks_acc_q <= '0;
      cks_q     <= '0;
    end else begin
      cks_acc_q <= cks_acc_d;
      cks_q     <= cks_d;
    end
  end

  assign bus.checksum_o = cks_q;
`else
  logic unused_pix;
  assign unused_pix     = ^{bus.rdata_i, bus.gdata_i, bus.bdata_i};
  assign bus.checksum_o = '0;
`endif

endmodule

// File: doc/tp_monitor.md
TP_MONITOR -- requirements
Module: tp_monitor

Interface
REQ-001 Parameter CNT_W, default 12: width of the pixel, line and active-size counters.
REQ-002 Parameter LOCK_FRAMES, default 2: number of consecutive identical, error-free frames required to assert locked_o.
REQ-003 px_clk  input  1  pixel clock; all logic on its rising edge.
REQ-004 sys_rst  input  1  reset, asynchronous, active-high.
REQ-005 vsync_i  input  1  frame sync, active-high; a rising edge starts a frame.
REQ-006 hsync_i  input  1  line sync, active-high; a rising edge starts a line.
REQ-007 dval_i  input  1  pixel-valid qualifier for rdata_i/gdata_i/bdata_i.
REQ-008 rdata_i, gdata_i, bdata_i  input  8 each  pixel colour components.
REQ-009 frame_done_o  output  1  one-cycle pulse when a frame's results are updated.
REQ-010 h_active_o  output  CNT_W  valid pixels per line, taken from the first non-empty line of the last completed frame.
REQ-011 v_active_o  output  CNT_W  number of non-empty lines in the last completed frame.
REQ-012 frame_cnt_o  output  16  completed frames since reset; wraps modulo 2^16.
REQ-013 err_o  output  1  pulse coincident with frame_done_o when the completed frame contained a line-width mismatch.
REQ-014 err_cnt_o  output  8  erroneous frames since reset; saturates at 255.
REQ-015 locked_o  output  1  stable-timing indicator.
REQ-016 checksum_o  output  16  pixel checksum of the last completed frame.

Function
REQ-017 All inputs SHALL be registered once; edge detection SHALL compare that register against its previous value.
REQ-018 The block SHALL use a two-state FSM:
- IDLE: entered on reset; dval_i, hsync_i and pixel data are ignored; the first vsync rising edge moves the FSM to ACTIVE and clears the working counters.
- ACTIVE: the block counts pixels and lines; each later vsync rising edge closes the frame and the FSM stays in ACTIVE.
REQ-019 In ACTIVE, each sampled dval_i=1 SHALL increment the pixel counter, saturating at 2^CNT_W-1.
REQ-020 Line close:
- Trigger: an hsync rising edge, or a vsync rising edge, occurring with a pixel count of 1 or more.
- Action: the line counter increments (saturating) and the pixel counter clears.
- Empty lines: an edge with a pixel count of 0 is not counted as a line.
REQ-021 Line-width check:
- The first closed line of a frame sets the reference width.
- Any later closed line with a different width sets the frame error flag.
REQ-022 Frame close on a vsync rising edge, in this order:
- Close the pending line.
- Latch h_active_o, v_active_o and checksum_o.
- Pulse frame_done_o and increment frame_cnt_o.
- Pulse err_o if the frame error flag is set; err_cnt_o increments only in that case.
- Clear the working state.
REQ-023 Latency: if vsync_i is first sampled high at edge k, frame_done_o and the updated results SHALL be valid for exactly the cycle between edges k+1 and k+2.
REQ-024 Priority: simultaneous hsync and vsync rising edges SHALL be handled as one frame close, with exactly one line closed.
REQ-025 A frame with zero closed lines SHALL report h_active_o=0 and v_active_o=0 and SHALL count as erroneous.
REQ-026 locked_o SHALL assert at the frame_done_o of the LOCK_FRAMES-th consecutive frame that is error-free and has the same h_active and v_active as its predecessor. It SHALL deassert at any frame_done_o that breaks this condition.
REQ-027 Checksum: 16-bit sum, modulo 2^16, of (rdata+gdata+bdata) over every valid pixel of the frame.

Reset
REQ-028 On sys_rst=1, asynchronously, all outputs SHALL be 0, the FSM SHALL be in IDLE, and all counters, flags and input registers SHALL be 0.
REQ-029 A reset asserted mid-frame SHALL discard the partial frame; after release, nothing SHALL be reported until the first complete frame bounded by two vsync rising edges.

Configuration
REQ-030 Macro TP_MONITOR_CHECKSUM_EN controls the checksum:
- Defined: checksum logic is implemented per REQ-027.
- Undefined: no checksum adder is built and checksum_o is constantly 0; all other behaviour is unchanged.

Verification
REQ-031 Stream of 3 lines of 4 valid pixels, each pixel r=1 g=2 b=3, between two vsync pulses -> h_active_o=4, v_active_o=3, checksum_o=72, err_o=0, frame_done_o one cycle wide at edge k+1.
REQ-032 Middle line of that frame shortened to 3 pixels -> err_o=1, err_cnt_o=1, locked_o=0.
REQ-033 Three identical good frames with LOCK_FRAMES=2 -> locked_o rises at the 3rd frame_done_o; a following 5-line frame -> locked_o falls at its frame_done_o.
REQ-034 hsync and vsync rising edges in the same cycle ending a 4-pixel line -> v_active_o counts that line once.
REQ-035 sys_rst pulsed mid-frame -> all outputs 0; the next frame_done_o follows the second vsync rising edge after reset release.
REQ-036 Build without TP_MONITOR_CHECKSUM_EN and rerun REQ-031 -> checksum_o=0, all other values identical.
